// File: rtl/alu_seq.sv
// alu_seq: picoMIPS sequential execute stage with 1-cycle ALU ops and an
// n+1 cycle signed Q1.(n-1) shift-add multiply.
// Ports:
//   clk, reset (sync, active-high)
//   start, op[2:0], a[n-1:0], b[n-1:0], rd_in[1:0] : issue side
//   busy, done, w, Wdata[n-1:0], rd_out[1:0], zero : result side
// Build option: define ALU_SAT_EN for saturating ADD/SUB/MUL.
module alu_seq #(
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic [1:0]   rd_in,
   output logic         busy,
   output logic         done,
   output logic         w,
   output logic [n-1:0] Wdata,
   output logic [1:0]   rd_out,
   output logic         zero
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;

   localparam int CW = (n > 1) ? $clog2(n) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

   localparam logic [n-1:0] VMIN = {1'b1, {(n-1){1'b0}}};
   localparam logic [n-1:0] VMAX = {1'b0, {(n-1){1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_FIN
   } state_t;

   state_t state, state_nx;
   logic   take;

   logic [2:0]     op_q;
   logic [n-1:0]   a_q;
   logic [n-1:0]   b_q;
   logic [1:0]     rd_q;
   logic [2*n-1:0] acc;
   logic [2*n-1:0] mcand;
   logic [n-1:0]   mplr;
   logic [CW-1:0]  cnt;

   logic [n-1:0]   a_mag;
   logic [n-1:0]   b_mag;

   logic [n-1:0]   sum;
   logic [n-1:0]   diff;
   logic           ovf_add;
   logic           ovf_sub;
   logic           neg;
   logic [2*n-1:0] prod;
   logic           both_min;
   logic [n-1:0]   add_r;
   logic [n-1:0]   sub_r;
   logic [n-1:0]   mul_r;
   logic [n-1:0]   res;
   logic           wr_ok;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next state; FIN accepts a new issue exactly like IDLE
   always_comb begin
      state_nx = state;
      take     = 1'b0;
      unique case (state)
         S_MUL: begin
            if (cnt == CNT_LAST) state_nx = S_FIN;
         end
         default: begin
            if (state == S_FIN) state_nx = S_IDLE;
            if (start) begin
               take     = 1'b1;
               state_nx = (op == OP_MUL) ? S_MUL : S_FIN;
            end
         end
      endcase
   end

   assign busy = (state == S_MUL);

   // Unsigned magnitudes; most-negative maps to 2^(n-1), still fits n bits
   assign a_mag = a[n-1] ? (~a + 1'b1) : a;
   assign b_mag = b[n-1] ? (~b + 1'b1) : b;

   // Result datapath, evaluated from the captured operands in FIN
   always_comb begin
      sum      = a_q + b_q;
      diff     = a_q - b_q;
      ovf_add  = (a_q[n-1] == b_q[n-1]) && (sum[n-1]  != a_q[n-1]);
      ovf_sub  = (a_q[n-1] != b_q[n-1]) && (diff[n-1] != a_q[n-1]);
      neg      = a_q[n-1] ^ b_q[n-1];
      prod     = neg ? (~acc + 1'b1) : acc;
      both_min = (a_q == VMIN) && (b_q == VMIN);
`ifdef ALU_SAT_EN
      add_r = ovf_add ? (a_q[n-1] ? VMIN : VMAX) : sum;
      sub_r = ovf_sub ? (a_q[n-1] ? VMIN : VMAX) : diff;
      mul_r = both_min ? VMAX : prod[2*n-2:n-1];
`else
      add_r = sum;
      sub_r = diff;
      mul_r = prod[2*n-2:n-1];
`endif
      res   = Wdata;
      wr_ok = 1'b1;
      case (op_q)
         OP_ADD:  res = add_r;
         OP_SUB:  res = sub_r;
         OP_AND:  res = a_q & b_q;
         OP_OR:   res = a_q | b_q;
         OP_MUL:  res = mul_r;
         default: wr_ok = 1'b0;
      endcase
   end

   // Operand capture, shift-add multiply and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         rd_q   <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplr   <= '0;
         cnt    <= '0;
         done   <= 1'b0;
         w      <= 1'b0;
         Wdata  <= '0;
         rd_out <= '0;
         zero   <= 1'b1;
      end else begin
         done <= 1'b0;
         w    <= 1'b0;
         if (take) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            rd_q  <= rd_in;
            acc   <= '0;
            mcand <= {{n{1'b0}}, a_mag};
            mplr  <= b_mag;
            cnt   <= '0;
         end else if (state == S_MUL) begin
            if (mplr[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
         end
         if (state == S_FIN) begin
            done   <= 1'b1;
            w      <= wr_ok;
            rd_out <= rd_q;
            if (wr_ok) begin
               Wdata <= res;
               zero  <= (res == '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (n=8).
// Expected results are queued at issue and popped when done rises.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic [1:0] rd_in;
   logic       busy;
   logic       done;
   logic       w;
   logic [7:0] Wdata;
   logic [1:0] rd_out;
   logic       zero;

   always #5 clk = ~clk;

   alu_seq #(.n(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .rd_in  (rd_in),
      .busy   (busy),
      .done   (done),
      .w      (w),
      .Wdata  (Wdata),
      .rd_out (rd_out),
      .zero   (zero)
   );

   typedef struct packed {
      logic       w;
      logic [7:0] d;
      logic [1:0] rd;
      logic       z;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic [7:0] m_wd = 8'h00;
   logic       m_z  = 1'b1;

   function automatic logic [7:0] model(input logic [2:0] o,
                                        input logic [7:0] x,
                                        input logic [7:0] y);
      logic signed [8:0]  s;
      logic signed [15:0] p;
      logic [7:0] r;
      r = 8'h00;
      case (o)
         3'd0, 3'd1: begin
            if (o == 3'd0) s = $signed({x[7], x}) + $signed({y[7], y});
            else           s = $signed({x[7], x}) - $signed({y[7], y});
            r = s[7:0];
`ifdef ALU_SAT_EN
            if (s > 9'sd127)  r = 8'h7F;
            if (s < -9'sd128) r = 8'h80;
`endif
         end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: begin
            p = $signed(x) * $signed(y);
            r = p[14:7];
`ifdef ALU_SAT_EN
            if (x == 8'h80 && y == 8'h80) r = 8'h7F;
`endif
         end
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic void push_exp(input logic [2:0] o,
                                    input logic [7:0] x,
                                    input logic [7:0] y,
                                    input logic [1:0] r);
      exp_t e;
      if (o <= 3'd4) begin
         m_wd = model(o, x, y);
         m_z  = (m_wd == 8'h00);
         e.w  = 1'b1;
      end else begin
         e.w  = 1'b0;
      end
      e.d  = m_wd;
      e.rd = r;
      e.z  = m_z;
      sb.push_back(e);
   endfunction

   task automatic wait_check(input string nm, input int exp_lat,
                             input int exp_busy);
      int   lat;
      int   bc;
      exp_t e;
      lat = 0;
      bc  = 0;
      while (!done && lat < 40) begin
         if (busy) bc++;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
      end
      checks++;
      if (bc !== exp_busy) begin
         errors++;
         $display("FAIL %s busy cycles: got %0d want %0d", nm, bc, exp_busy);
      end
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty", nm);
         return;
      end
      e = sb.pop_front();
      checks++;
      if ({w, Wdata, rd_out, zero} !== {e.w, e.d, e.rd, e.z}) begin
         errors++;
         $display("FAIL %s result: got w=%b d=%h rd=%0d z=%b want w=%b d=%h rd=%0d z=%b",
                  nm, w, Wdata, rd_out, zero, e.w, e.d, e.rd, e.z);
      end
   endtask

   // Called at a negedge; returns at the negedge of the done cycle
   task automatic run_op(input string nm, input logic [2:0] o,
                         input logic [7:0] x, input logic [7:0] y,
                         input logic [1:0] r);
      op    = o;
      a     = x;
      b     = y;
      rd_in = r;
      start = 1'b1;
      push_exp(o, x, y, r);
      @(negedge clk);
      start = 1'b0;
      op    = 3'($urandom);
      a     = 8'($urandom);
      b     = 8'($urandom);
      rd_in = 2'($urandom);
      if (o == 3'd4) wait_check(nm, 9, 8);
      else           wait_check(nm, 1, 0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      a     = 8'h00;
      b     = 8'h00;
      rd_in = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, w, Wdata, rd_out, zero} !== {3'b000, 8'h00, 2'd0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state: got b=%b d=%b w=%b wd=%h rd=%0d z=%b",
                  busy, done, w, Wdata, rd_out, zero);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add();
      run_op("add_05_03", 3'd0, 8'h05, 8'h03, 2'd2);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || w !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: got done=%b w=%b want 0 0", done, w);
      end
      checks++;
      if (Wdata !== 8'h08) begin
         errors++;
         $display("FAIL wdata_hold: got %h want 08", Wdata);
      end
   endtask

   task automatic test_addsub_ovf();
      run_op("add_70_20", 3'd0, 8'h70, 8'h20, 2'd1);
      run_op("sub_05_05", 3'd1, 8'h05, 8'h05, 2'd3);
      run_op("sub_80_01", 3'd1, 8'h80, 8'h01, 2'd0);
      run_op("add_80_ff", 3'd0, 8'h80, 8'hFF, 2'd2);
   endtask

   task automatic test_logic_nop();
      run_op("or_a5_0f", 3'd3, 8'hA5, 8'h0F, 2'd1);
      run_op("nop_5",    3'd5, 8'h12, 8'h34, 2'd2);
      run_op("and_0f_f0", 3'd2, 8'h0F, 8'hF0, 2'd3);
      run_op("nop_7",    3'd7, 8'hFF, 8'hFF, 2'd0);
   endtask

   task automatic test_mul();
      run_op("mul_40_40", 3'd4, 8'h40, 8'h40, 2'd1);
      run_op("mul_c0_40", 3'd4, 8'hC0, 8'h40, 2'd2);
      run_op("mul_80_80", 3'd4, 8'h80, 8'h80, 2'd3);
      run_op("mul_ff_01", 3'd4, 8'hFF, 8'h01, 2'd0);
      run_op("mul_7f_81", 3'd4, 8'h7F, 8'h81, 2'd1);
   endtask

   task automatic test_busy_ignore();
      bit extra;
      op    = 3'd4;
      a     = 8'h40;
      b     = 8'h40;
      rd_in = 2'd2;
      start = 1'b1;
      push_exp(3'd4, 8'h40, 8'h40, 2'd2);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      op    = 3'd0;
      a     = 8'h11;
      b     = 8'h22;
      rd_in = 2'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = 8'h7F;
      b     = 8'h7F;
      wait_check("busy_ignore", 6, 5);
      extra = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done) extra = 1'b1;
      end
      checks++;
      if (extra !== 1'b0) begin
         errors++;
         $display("FAIL busy_not_queued: got extra done=%b want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      run_op("b2b_mul", 3'd4, 8'h40, 8'hC0, 2'd1);
      run_op("b2b_and", 3'd2, 8'hF0, 8'h3C, 2'd2);
      run_op("b2b_sub", 3'd1, 8'h10, 8'h20, 2'd3);
      run_op("b2b_mul2", 3'd4, 8'h60, 8'h60, 2'd0);
   endtask

   task automatic test_reset_mid_mul();
      bit wseen;
      op    = 3'd4;
      a     = 8'h40;
      b     = 8'h40;
      rd_in = 2'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wseen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (w) wseen = 1'b1;
      end
      reset = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (w) wseen = 1'b1;
      end
      reset = 1'b0;
      m_wd  = 8'h00;
      m_z   = 1'b1;
      checks++;
      if ({busy, Wdata, zero} !== {1'b0, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL reset_mid_mul: got busy=%b wd=%h z=%b want 0 00 1",
                  busy, Wdata, zero);
      end
      repeat (12) begin
         @(negedge clk);
         if (w || done) wseen = 1'b1;
      end
      checks++;
      if (wseen !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_write: got w seen=%b want 0", wseen);
      end
   endtask

   task automatic test_random();
      logic [2:0] o;
      for (int i = 0; i < 12; i++) begin
         o = 3'($urandom_range(0, 7));
         run_op("random", o, 8'($urandom), 8'($urandom), 2'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_addsub_ovf();
      test_logic_nop();
      test_mul();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_mul();
      test_random();
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
